sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's fixed-size synchronous FIFO. It adds configurable data width and depth, correct simultaneous read/write handling at the full and empty boundaries, programmable almost-full and almost-empty flags, synchronous flush, and one-cycle overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain, as a rate-matching buffer on the 32-bit datapath.

## Interface
- DATA_W, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- CW: derived, $clog2(DEPTH)+1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (assert 0 = reset; deassertion is synchronised externally)
- wr  input  1  write request
- rd  input  1  read request
- flush  input  1  synchronous clear of contents
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  registered read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- fifo_cnt  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected
- underflow  output  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH × DATA_W array; write and read pointers each $clog2(DEPTH) bits, incremented by 1 and wrapping naturally from DEPTH-1 to 0.
- Read accepted (rd_ok) = rd && !empty.
- Write accepted (wr_ok) = wr && (!full || rd_ok). Full with wr and rd both high: both accepted, count stays DEPTH.
- Empty with wr and rd both high: write accepted, read rejected, underflow pulses, count becomes 1.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither. Count never exceeds DEPTH or drops below 0.
- wr_ok: mem[wr_ptr] ← data_in, wr_ptr++.
- rd_ok: data_out ← mem[rd_ptr], rd_ptr++. data_out holds its value when no read is accepted.
- overflow = registered (wr && !wr_ok); underflow = registered (rd && !rd_ok). Each is high for exactly the cycle after the rejected request.
- flush = 1 at an edge: wr_ptr, rd_ptr and count ← 0, and wr/rd in that cycle are ignored; data_out holds; overflow/underflow ← 0. Flush has priority over wr/rd. rst has priority over everything.
- full, empty, almost_full and almost_empty are decoded combinationally from the count register only. No combinational path from wr/rd to any output.
- Reset (rst = 0, asynchronous): pointers 0, fifo_cnt 0, data_out 0, overflow 0, underflow 0. Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_LEVEL ≥ 1). Memory contents are not reset.
- Reset mid-operation: all state clears immediately, independent of clk. Data queued before reset is lost and is never presented on data_out.

## Timing
- Write-to-visible latency: a word written at edge N can be read (rd_ok) at edge N+1 and appears on data_out after edge N+1.
- Read latency: 1 cycle. data_out is valid the cycle after the edge at which rd_ok was true.
- Flags and fifo_cnt reflect the state after each edge, with no same-cycle lookahead.
- Throughput: one write and one read per cycle sustained, including at full and at empty-with-write.
- The first edge after rst deasserts is a normal operating edge.

## Test plan
- Reset then fill (DEPTH = 8, DATA_W = 32): write 0x00..0x07 on 8 consecutive cycles -> fifo_cnt steps 1..8. almost_full rises when fifo_cnt reaches 6. full = 1 after the 8th edge. A 9th write -> overflow pulses for 1 cycle and fifo_cnt stays 8.
- Drain: from full, read 8 cycles -> data_out = 0x00..0x07 in order, each one cycle after its read. almost_empty rises when fifo_cnt reaches 2. empty = 1 after the 8th read. A 9th read -> underflow pulses and data_out holds 0x07.
- Simultaneous at boundaries: at full, wr = rd = 1 with data 0xAA -> fifo_cnt stays 8 and the oldest word is output. At empty, wr = rd = 1 with 0xBB -> fifo_cnt = 1, underflow pulses, and a next-cycle read returns 0xBB.
- Wrap-around: 20 cycles of continuous write and read with count held at 3 and an incrementing pattern -> output sequence matches input exactly, with pointers wrapping past 7 twice.
- Flush: with 5 entries, flush = 1 together with wr = 1 -> fifo_cnt = 0, empty = 1, the written word is discarded, and data_out is unchanged.
- Async reset mid-stream: drop rst between clock edges with fifo_cnt = 4 -> all outputs go to reset values before the next edge. After release, a read gives underflow and no stale data.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: request, data and status signals.
interface sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr;
    logic              rd;
    logic              flush;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     fifo_cnt;
    logic              overflow;
    logic              underflow;

    // Side that drives requests and observes status (producer/consumer).
    modport master (
        output wr, rd, flush, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wr, rd, flush, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, programmable
// almost flags, synchronous flush and one-cycle overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] dout;
    logic              ovf;
    logic              unf;
    logic              rd_ok;
    logic              wr_ok;
    logic              full_i;
    logic              empty_i;

    // Status decode from the count register only; a read frees a slot for a same-cycle write.
    always_comb begin
        full_i  = (cnt == DEPTH_C);
        empty_i = (cnt == '0);
        rd_ok   = bus.rd && !empty_i;
        wr_ok   = bus.wr && (!full_i || rd_ok);
    end

    // Storage is not reset; pointers alone decide what is readable.
    always_ff @(posedge clk) begin
        if (rst && !bus.flush && wr_ok)
            mem[wr_ptr] <= bus.data_in;
    end

    // Pointers, occupancy, read data and error pulses; flush overrides requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            ovf <= bus.wr && !wr_ok;
            unf <= bus.rd && !rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.data_out     = dout;
    assign bus.fifo_cnt     = cnt;
    assign bus.full         = full_i;
    assign bus.empty        = empty_i;
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH 8, DATA_W 32).
module tb_sync_fifo_param;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sync_fifo_param_if #(.DATA_W(32), .DEPTH(8)) bus ();

    sync_fifo_param #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle();
        bus.data_in = '0;
        repeat (3) step();

        // reset state
        chk("rst_cnt", bus.fifo_cnt, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ae", bus.almost_empty, 1);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_unf", bus.underflow, 0);
        rst = 1'b1;

        // fill 0..7
        for (int i = 0; i < 8; i++) begin
            bus.wr = 1'b1;
            bus.data_in = i;
            step();
            chk("fill_cnt", bus.fifo_cnt, i + 1);
            chk("fill_af", bus.almost_full, (i + 1) >= 6);
            chk("fill_full", bus.full, (i + 1) == 8);
        end
        bus.data_in = 32'h99;
        step();
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_cnt", bus.fifo_cnt, 8);
        idle();
        step();
        chk("ovf_clear", bus.overflow, 0);

        // drain
        for (int i = 0; i < 8; i++) begin
            bus.rd = 1'b1;
            step();
            chk("drain_dout", bus.data_out, i);
            chk("drain_cnt", bus.fifo_cnt, 7 - i);
            chk("drain_ae", bus.almost_empty, (7 - i) <= 2);
            chk("drain_empty", bus.empty, i == 7);
        end
        step();
        chk("unf_pulse", bus.underflow, 1);
        chk("unf_hold", bus.data_out, 7);
        idle();
        step();
        chk("unf_clear", bus.underflow, 0);

        // simultaneous at full
        for (int i = 0; i < 8; i++) begin
            bus.wr = 1'b1;
            bus.data_in = 32'h10 + i;
            step();
        end
        chk("refill_full", bus.full, 1);
        bus.rd = 1'b1;
        bus.data_in = 32'hAA;
        step();
        chk("sim_full_cnt", bus.fifo_cnt, 8);
        chk("sim_full_dout", bus.data_out, 32'h10);
        chk("sim_full_ovf", bus.overflow, 0);
        bus.wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("sim_drain", bus.data_out, (i == 7) ? 32'hAA : 32'h11 + i);
        end
        chk("sim_drain_empty", bus.empty, 1);

        // simultaneous at empty
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        bus.data_in = 32'hBB;
        step();
        chk("sim_empty_cnt", bus.fifo_cnt, 1);
        chk("sim_empty_unf", bus.underflow, 1);
        chk("sim_empty_hold", bus.data_out, 32'hAA);
        bus.wr = 1'b0;
        step();
        chk("sim_empty_rd", bus.data_out, 32'hBB);
        chk("sim_empty_cnt0", bus.fifo_cnt, 0);
        chk("sim_empty_unf0", bus.underflow, 0);
        idle();

        // wrap-around at count 3
        for (int i = 0; i < 3; i++) begin
            bus.wr = 1'b1;
            bus.data_in = 32'h100 + i;
            step();
        end
        bus.rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.data_in = 32'h103 + i;
            step();
            chk("wrap_dout", bus.data_out, 32'h100 + i);
            chk("wrap_cnt", bus.fifo_cnt, 3);
        end
        bus.wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_tail", bus.data_out, 32'h114 + i);
        end
        idle();

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) begin
            bus.wr = 1'b1;
            bus.data_in = 32'h200 + i;
            step();
        end
        chk("pre_flush_cnt", bus.fifo_cnt, 5);
        bus.flush = 1'b1;
        bus.data_in = 32'hDEAD;
        step();
        chk("flush_cnt", bus.fifo_cnt, 0);
        chk("flush_empty", bus.empty, 1);
        chk("flush_dout", bus.data_out, 32'h116);
        idle();
        bus.rd = 1'b1;
        step();
        chk("flush_rd_unf", bus.underflow, 1);
        chk("flush_rd_dout", bus.data_out, 32'h116);
        idle();

        // async reset mid-stream
        for (int i = 0; i < 4; i++) begin
            bus.wr = 1'b1;
            bus.data_in = 32'h300 + i;
            step();
        end
        idle();
        chk("pre_rst_cnt", bus.fifo_cnt, 4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cnt", bus.fifo_cnt, 0);
        chk("arst_empty", bus.empty, 1);
        chk("arst_dout", bus.data_out, 0);
        chk("arst_ae", bus.almost_empty, 1);
        chk("arst_unf", bus.underflow, 0);
        step();
        rst = 1'b1;
        bus.rd = 1'b1;
        step();
        chk("post_rst_unf", bus.underflow, 1);
        chk("post_rst_dout", bus.data_out, 0);
        chk("post_rst_cnt", bus.fifo_cnt, 0);
        bus.rd = 1'b0;
        bus.wr = 1'b1;
        bus.data_in = 32'h400;
        step();
        bus.wr = 1'b0;
        bus.rd = 1'b1;
        step();
        chk("post_rst_fresh", bus.data_out, 32'h400);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
